pwm_duty_ramp: RTL and testbench

Soft-start and reversal sequencer between the closed-loop speed controller and the PWM generator. Accepts a duty magnitude plus direction command, slews the 8-bit duty toward it at a programmable rate, and drives the PWM generator's duty input. On a direction change it ramps to zero, disables the H-bridge for a dead time, flips direction, then ramps back up. An emergency stop forces zero duty at once.

---
 rtl/pwm_duty_ramp.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start and reversal sequencer feeding a PWM generator.
// Slews the duty toward the commanded magnitude at a programmable rate, walks
// through zero with a dead time on direction changes, and zeroes the duty
// immediately on emergency stop.
//
// Ports:
//   CLK        clock
//   RESET      synchronous active-high reset
//   CMD_DC     requested duty magnitude
//   CMD_DIR    requested direction (0 = forward)
//   CMD_VALID  loads CMD_DC/CMD_DIR into the target registers
//   ESTOP      level emergency stop
//   OUT_DC     registered duty to the PWM generator
//   OUT_DIR    registered H-bridge direction
//   OUT_EN     registered H-bridge enable
//   AT_TARGET  registered: idle with output equal to target
module pwm_duty_ramp #(
    parameter int unsigned DC_WIDTH        = 8,
    parameter int unsigned RAMP_DIV        = 1000,
    parameter int unsigned RAMP_STEP       = 1,
    parameter int unsigned DEADTIME_CYCLES = 100
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [DC_WIDTH-1:0] CMD_DC,
    input  logic                CMD_DIR,
    input  logic                CMD_VALID,
    input  logic                ESTOP,
    output logic [DC_WIDTH-1:0] OUT_DC,
    output logic                OUT_DIR,
    output logic                OUT_EN,
    output logic                AT_TARGET
);

    localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam int unsigned SUM_W  = DC_WIDTH + 1;

    localparam logic [SUM_W-1:0]  STEP_EXT  = SUM_W'(RAMP_STEP);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RAMP,
        ST_RAMP_DOWN,
        ST_DEAD,
        ST_ESTOP
    } state_t;

    state_t              state_q, state_d;
    logic [DC_WIDTH-1:0] out_dc_q, out_dc_d;
    logic                out_dir_q, out_dir_d;
    logic                out_en_q, out_en_d;
    logic                at_target_q, at_target_d;
    logic [DC_WIDTH-1:0] tgt_dc_q, tgt_dc_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;

    logic                tick;
    logic                rev_req;
    logic [SUM_W-1:0]    up_sum;
    logic [SUM_W-1:0]    dn_diff;
    logic [DC_WIDTH-1:0] step_tgt;
    logic [DC_WIDTH-1:0] step_zero;

    // Free-running ramp prescaler
    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // One ramp step, computed one bit wider so the duty can never wrap
    always_comb begin
        up_sum  = {1'b0, out_dc_q} + STEP_EXT;
        dn_diff = {1'b0, out_dc_q} - STEP_EXT;
        if (tgt_dc_q > out_dc_q) begin
            step_tgt = (up_sum >= {1'b0, tgt_dc_q}) ? tgt_dc_q : up_sum[DC_WIDTH-1:0];
        end else begin
            step_tgt = (dn_diff[DC_WIDTH] || (dn_diff[DC_WIDTH-1:0] <= tgt_dc_q))
                       ? tgt_dc_q : dn_diff[DC_WIDTH-1:0];
        end
        step_zero = dn_diff[DC_WIDTH] ? '0 : dn_diff[DC_WIDTH-1:0];
    end

    // A zero-magnitude target never triggers a reversal
    assign rev_req = (tgt_dir_q != out_dir_q) && (tgt_dc_q != '0);

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        out_dc_d   = out_dc_q;
        out_dir_d  = out_dir_q;
        out_en_d   = out_en_q;
        tgt_dc_d   = tgt_dc_q;
        tgt_dir_d  = tgt_dir_q;
        dead_cnt_d = '0;

        case (state_q)
            ST_HOLD: begin
                if (rev_req) begin
                    if (out_dc_q == '0) begin
                        state_d  = ST_DEAD;
                        out_en_d = 1'b0;
                    end else begin
                        state_d = ST_RAMP_DOWN;
                    end
                end else if (out_dc_q != tgt_dc_q) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (rev_req) begin
                    state_d = ST_RAMP_DOWN;
                end else if (out_dc_q == tgt_dc_q) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    out_dc_d = step_tgt;
                    if (step_tgt == tgt_dc_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (out_dc_q == '0) begin
                    state_d  = ST_DEAD;
                    out_en_d = 1'b0;
                end else if (tick) begin
                    out_dc_d = step_zero;
                    if (step_zero == '0) begin
                        state_d  = ST_DEAD;
                        out_en_d = 1'b0;
                    end
                end
            end
            ST_DEAD: begin
                out_dc_d = '0;
                out_en_d = 1'b0;
                if (dead_cnt_q == DEAD_LAST) begin
                    // Direction is taken from the target as it stands at exit
                    out_en_d  = 1'b1;
                    out_dir_d = tgt_dir_q;
                    state_d   = (tgt_dc_q == '0) ? ST_HOLD : ST_RAMP;
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
            ST_ESTOP: begin
                out_dc_d = '0;
                out_en_d = 1'b0;
                if (!ESTOP) begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d  = ST_DEAD;
                out_dc_d = '0;
                out_en_d = 1'b0;
            end
        endcase

        if (CMD_VALID && !ESTOP) begin
            tgt_dc_d  = CMD_DC;
            tgt_dir_d = CMD_DIR;
        end

        // Emergency stop overrides everything except reset
        if (ESTOP) begin
            state_d    = ST_ESTOP;
            out_dc_d   = '0;
            out_en_d   = 1'b0;
            tgt_dc_d   = '0;
            dead_cnt_d = '0;
        end

        at_target_d = (state_d == ST_HOLD) && (out_dc_d == tgt_dc_d) &&
                      ((out_dir_d == tgt_dir_d) || (tgt_dc_d == '0));
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_DEAD;
            out_dc_q    <= '0;
            out_dir_q   <= 1'b0;
            out_en_q    <= 1'b0;
            at_target_q <= 1'b0;
            tgt_dc_q    <= '0;
            tgt_dir_q   <= 1'b0;
            pre_cnt_q   <= '0;
            dead_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_dc_q    <= out_dc_d;
            out_dir_q   <= out_dir_d;
            out_en_q    <= out_en_d;
            at_target_q <= at_target_d;
            tgt_dc_q    <= tgt_dc_d;
            tgt_dir_q   <= tgt_dir_d;
            pre_cnt_q   <= pre_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end

    assign OUT_DC    = out_dc_q;
    assign OUT_DIR   = out_dir_q;
    assign OUT_EN    = out_en_q;
    assign AT_TARGET = at_target_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Testbench for pwm_duty_ramp with RAMP_DIV=4, RAMP_STEP=16, DEADTIME_CYCLES=8.
// Same-direction ramps are table driven; reversal, dead-time command latching,
// emergency stop and mid-ramp reset are hand-written sequences.
module tb_pwm_duty_ramp;

    logic       CLK;
    logic       RESET;
    logic [7:0] CMD_DC;
    logic       CMD_DIR;
    logic       CMD_VALID;
    logic       ESTOP;
    logic [7:0] OUT_DC;
    logic       OUT_DIR;
    logic       OUT_EN;
    logic       AT_TARGET;

    int ncomp = 0;
    int nfail = 0;
    int cyc   = 0;

    pwm_duty_ramp #(
        .DC_WIDTH       (8),
        .RAMP_DIV       (4),
        .RAMP_STEP      (16),
        .DEADTIME_CYCLES(8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CMD_DC   (CMD_DC),
        .CMD_DIR  (CMD_DIR),
        .CMD_VALID(CMD_VALID),
        .ESTOP    (ESTOP),
        .OUT_DC   (OUT_DC),
        .OUT_DIR  (OUT_DIR),
        .OUT_EN   (OUT_EN),
        .AT_TARGET(AT_TARGET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Command, expected duty sequence, expected final direction
    typedef struct {
        int dc;
        int dir;
        int edir;
        int n;
        int seq[16];
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ncomp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int dc, input int dir);
        CMD_DC    = 8'(dc);
        CMD_DIR   = dir[0];
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Wait (bounded) for the next OUT_DC change; gap is cycles waited
    task automatic next_dc(input string nm, input int exp, output int gap);
        logic [7:0] prev;
        int         start;
        bit         seen;
        prev  = OUT_DC;
        start = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            if (OUT_DC != prev) seen = 1'b1;
        end
        gap = cyc - start;
        chk(nm, seen ? int'(OUT_DC) : -1, exp);
    endtask

    // Count cycles until OUT_EN rises (bounded)
    task automatic wait_en(input string nm, input int exp);
        int n;
        n = 0;
        while (!OUT_EN && n < 40) begin
            tick();
            n++;
        end
        chk(nm, OUT_EN ? n : -1, exp);
    endtask

    initial begin
        int gap;
        int n;

        vecs[0] = '{64, 0, 0, 4,
                    '{16, 32, 48, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{40, 0, 0, 2,
                    '{48, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{0, 0, 0, 3,
                    '{24, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{255, 0, 0, 16,
                    '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240, 255}};
        vecs[4] = '{64, 0, 0, 12,
                    '{239, 223, 207, 191, 175, 159, 143, 127, 111, 95, 79, 64, 0, 0, 0, 0}};
        // Zero magnitude in the other direction: ramp to 0, no reversal
        vecs[5] = '{0, 1, 0, 4,
                    '{48, 32, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[6] = '{64, 0, 0, 4,
                    '{16, 32, 48, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

        RESET     = 1'b1;
        CMD_DC    = 8'd0;
        CMD_DIR   = 1'b0;
        CMD_VALID = 1'b0;
        ESTOP     = 1'b0;
        repeat (3) tick();
        chk("rst_dc",  int'(OUT_DC), 0);
        chk("rst_en",  int'(OUT_EN), 0);
        chk("rst_dir", int'(OUT_DIR), 0);
        chk("rst_at",  int'(AT_TARGET), 0);

        RESET = 1'b0;
        wait_en("rst_dead_len", 8);
        chk("rst_exit_dc",  int'(OUT_DC), 0);
        chk("rst_exit_dir", int'(OUT_DIR), 0);
        chk("rst_exit_at",  int'(AT_TARGET), 1);

        // Same-direction ramps, one step per tick
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].dc, vecs[v].dir);
            for (int k = 0; k < vecs[v].n; k++) begin
                next_dc($sformatf("v%0d_step%0d", v, k), vecs[v].seq[k], gap);
                if (k > 0) chk($sformatf("v%0d_gap%0d", v, k), gap, 4);
            end
            repeat (6) tick();
            chk($sformatf("v%0d_hold_dc", v), int'(OUT_DC), vecs[v].seq[vecs[v].n-1]);
            chk($sformatf("v%0d_at", v),      int'(AT_TARGET), 1);
            chk($sformatf("v%0d_dir", v),     int'(OUT_DIR), vecs[v].edir);
            chk($sformatf("v%0d_en", v),      int'(OUT_EN), 1);
        end

        // Reversal 64/fwd -> 32/rev
        send(32, 1);
        next_dc("rev_48", 48, gap);
        next_dc("rev_32", 32, gap);
        chk("rev_gap32", gap, 4);
        next_dc("rev_16", 16, gap);
        next_dc("rev_0", 0, gap);
        chk("rev_gap0", gap, 4);
        chk("rev_en_off", int'(OUT_EN), 0);
        wait_en("rev_dead_len", 8);
        chk("rev_dir", int'(OUT_DIR), 1);
        chk("rev_exit_dc", int'(OUT_DC), 0);
        next_dc("rev_up16", 16, gap);
        next_dc("rev_up32", 32, gap);
        chk("rev_up_gap", gap, 4);
        chk("rev_at", int'(AT_TARGET), 1);

        // Reset in the middle of a ramp
        send(96, 1);
        next_dc("mid_48", 48, gap);
        RESET = 1'b1;
        tick();
        chk("mid_rst_dc",  int'(OUT_DC), 0);
        chk("mid_rst_en",  int'(OUT_EN), 0);
        chk("mid_rst_dir", int'(OUT_DIR), 0);
        chk("mid_rst_at",  int'(AT_TARGET), 0);
        RESET = 1'b0;
        wait_en("mid_dead_len", 8);
        chk("mid_exit_at", int'(AT_TARGET), 1);

        // Command landing during dead time overrides the pending reversal
        send(48, 0);
        next_dc("dl_16", 16, gap);
        next_dc("dl_32", 32, gap);
        next_dc("dl_48", 48, gap);
        send(32, 1);
        next_dc("dl_dn32", 32, gap);
        next_dc("dl_dn16", 16, gap);
        next_dc("dl_dn0", 0, gap);
        n = 0;
        while (!OUT_EN && n < 40) begin
            if (n == 2) begin
                CMD_DC    = 8'd32;
                CMD_DIR   = 1'b0;
                CMD_VALID = 1'b1;
            end
            tick();
            CMD_VALID = 1'b0;
            n++;
        end
        chk("dl_dead_len", OUT_EN ? n : -1, 8);
        chk("dl_dir", int'(OUT_DIR), 0);
        next_dc("dl_up16", 16, gap);
        next_dc("dl_up32", 32, gap);
        chk("dl_at", int'(AT_TARGET), 1);
        chk("dl_dir_end", int'(OUT_DIR), 0);

        // Emergency stop at 48, with a competing command held during stop
        send(128, 0);
        next_dc("es_48", 48, gap);
        ESTOP = 1'b1;
        tick();
        chk("es_dc", int'(OUT_DC), 0);
        chk("es_en", int'(OUT_EN), 0);
        chk("es_at", int'(AT_TARGET), 0);
        CMD_DC    = 8'd200;
        CMD_DIR   = 1'b1;
        CMD_VALID = 1'b1;
        repeat (3) tick();
        chk("es_hold_dc", int'(OUT_DC), 0);
        chk("es_hold_en", int'(OUT_EN), 0);
        ESTOP     = 1'b0;
        CMD_VALID = 1'b0;
        // One edge to leave the stop state, then the full dead time
        wait_en("es_dead_len", 9);
        chk("es_exit_dc",  int'(OUT_DC), 0);
        chk("es_exit_dir", int'(OUT_DIR), 0);
        chk("es_exit_at",  int'(AT_TARGET), 1);
        repeat (12) tick();
        chk("es_idle_dc", int'(OUT_DC), 0);
        chk("es_idle_at", int'(AT_TARGET), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
